// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage: operand bus, ALU selector, register index and opcode constants.
package alu_issue_stage_pkg;

  localparam int NREGS = 32;
  localparam int IDX_W = $clog2(NREGS);

  typedef logic [31:0]      bus_t;
  typedef logic [IDX_W-1:0] reg_idx_t;
  typedef logic [31:0]      instr_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SUB = 3'd3,
    ALU_SLT = 3'd4,
    ALU_NOR = 3'd5
  } oper_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;

  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;
  localparam logic [5:0] FN_NOR = 6'h27;

endpackage

// File: rtl/alu_issue_stage_reg_file.sv
// 32x32 register file, 2 async read ports, 1 write port, r0 reads as zero.
// FORWARD_EN: same-cycle write data is bypassed to matching read ports; reads are combinational.
module alu_issue_stage_reg_file
  import alu_issue_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  reg_idx_t raddr_a,
  input  reg_idx_t raddr_b,
  output bus_t     rdata_a,
  output bus_t     rdata_b,
  input  logic     we,
  input  reg_idx_t waddr,
  input  bus_t     wdata
);

  bus_t mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && waddr != '0) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
    rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];
`ifdef FORWARD_EN
    if (we && waddr != '0 && waddr == raddr_a) rdata_a = wdata;
    if (we && waddr != '0 && waddr == raddr_b) rdata_b = wdata;
`endif
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage feeding the ALU with a RAW scoreboard; 1-cycle latency, output held while !out_ready.
// FORWARD_EN enables writeback bypass so a dependent instruction issues in the writeback cycle.
module alu_issue_stage
  import alu_issue_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  output logic     in_ready,
  input  instr_t   in_instr,
  output logic     out_valid,
  input  logic     out_ready,
  output bus_t     out_a,
  output bus_t     out_b,
  output oper_t    out_sel,
  output reg_idx_t out_rd,
  input  logic     wb_valid,
  input  reg_idx_t wb_rd,
  input  bus_t     wb_data,
  output logic     illegal
);

  logic [5:0]  opcode, funct;
  reg_idx_t    rs, rt, rd_f;
  logic [15:0] imm;
  logic        unused_shamt;

  assign opcode       = in_instr[31:26];
  assign rs           = in_instr[25:21];
  assign rt           = in_instr[20:16];
  assign rd_f         = in_instr[15:11];
  assign funct        = in_instr[5:0];
  assign imm          = in_instr[15:0];
  assign unused_shamt = ^in_instr[10:6];

  logic     legal, use_rt;
  oper_t    dec_sel;
  reg_idx_t dec_rd;
  bus_t     imm_val;

  always_comb begin
    legal   = 1'b0;
    use_rt  = 1'b0;
    dec_sel = ALU_AND;
    dec_rd  = '0;
    imm_val = '0;
    case (opcode)
      OPC_RTYPE: begin
        legal  = 1'b1;
        use_rt = 1'b1;
        dec_rd = rd_f;
        case (funct)
          FN_AND:  dec_sel = ALU_AND;
          FN_OR:   dec_sel = ALU_OR;
          FN_ADD:  dec_sel = ALU_ADD;
          FN_SUB:  dec_sel = ALU_SUB;
          FN_SLT:  dec_sel = ALU_SLT;
          FN_NOR:  dec_sel = ALU_NOR;
          default: legal   = 1'b0;
        endcase
      end
      OPC_ADDI: begin
        legal = 1'b1; dec_sel = ALU_ADD; dec_rd = rt; imm_val = {{16{imm[15]}}, imm};
      end
      OPC_SLTI: begin
        legal = 1'b1; dec_sel = ALU_SLT; dec_rd = rt; imm_val = {{16{imm[15]}}, imm};
      end
      OPC_ANDI: begin
        legal = 1'b1; dec_sel = ALU_AND; dec_rd = rt; imm_val = {16'h0000, imm};
      end
      OPC_ORI: begin
        legal = 1'b1; dec_sel = ALU_OR; dec_rd = rt; imm_val = {16'h0000, imm};
      end
      default: ;
    endcase
  end

  bus_t rd_a, rd_b;

  alu_issue_stage_reg_file u_rf (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rd_a),
    .rdata_b (rd_b),
    .we      (wb_valid),
    .waddr   (wb_rd),
    .wdata   (wb_data)
  );

  logic [NREGS-1:0] pending, pending_nxt, pend_eff;
  logic             hazard, accept, issue;

  // With bypass, a register being written back this cycle is already available.
  always_comb begin
    pend_eff = pending;
`ifdef FORWARD_EN
    if (wb_valid) pend_eff[wb_rd] = 1'b0;
`endif
  end

  assign hazard   = legal && ((rs != '0 && pend_eff[rs]) ||
                              (use_rt && rt != '0 && pend_eff[rt]));
  assign in_ready = !hazard && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign issue    = accept && legal;

  // Set after clear: a new producer issued alongside a writeback owns the register.
  always_comb begin
    pending_nxt = pending;
    if (wb_valid) pending_nxt[wb_rd] = 1'b0;
    if (issue)    pending_nxt[dec_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_sel   <= ALU_AND;
      out_rd    <= '0;
      illegal   <= 1'b0;
    end else begin
      pending <= pending_nxt;
      illegal <= accept && !legal;
      if (issue) begin
        out_valid <= 1'b1;
        out_a     <= rd_a;
        out_b     <= use_rt ? rd_b : imm_val;
        out_sel   <= dec_sel;
        out_rd    <= dec_rd;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage (default and FORWARD_EN builds).
module tb_alu_issue_stage;
  import alu_issue_stage_pkg::*;

  logic     clk = 1'b0;
  logic     rst_n;
  logic     in_valid, in_ready, out_valid, out_ready, wb_valid, illegal;
  instr_t   in_instr;
  bus_t     out_a, out_b, wb_data;
  oper_t    out_sel;
  reg_idx_t out_rd, wb_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sel(out_sel), .out_rd(out_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  function automatic instr_t rtype(input reg_idx_t rs, input reg_idx_t rt, input reg_idx_t rd,
                                   input logic [5:0] fn);
    return {OPC_RTYPE, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic instr_t itype(input logic [5:0] op, input reg_idx_t rs, input reg_idx_t rt,
                                   input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wb(input reg_idx_t rd, input bus_t data);
    wb_valid = 1'b1; wb_rd = rd; wb_data = data;
    step();
    wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    in_instr = rtype(5'd0, 5'd0, 5'd0, FN_AND);
    #12;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL rst_illegal got %b want 0", illegal); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    n_cmp++; if (out_a !== 32'd0 || out_b !== 32'd0 || out_rd !== 5'd0)
      begin n_err++; $display("FAIL rst_operands got a=%h b=%h rd=%0d want 0/0/0", out_a, out_b, out_rd); end
    n_cmp++; if (out_sel !== ALU_AND) begin n_err++; $display("FAIL rst_sel got %0d want AND", out_sel); end
    step();
    rst_n = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i < NREGS; i++) begin
      in_instr = rtype(reg_idx_t'(i), reg_idx_t'(i), 5'd0, FN_OR);
      step();
      n_cmp++;
      if (out_valid !== 1'b1 || out_a !== 32'd0 || out_b !== 32'd0) begin
        n_err++; $display("FAIL rst_read_r%0d got v=%b a=%h b=%h want 1/0/0", i, out_valid, out_a, out_b);
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_issue_and_hazard();
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd3);
    in_instr = rtype(5'd1, 5'd2, 5'd3, FN_ADD); in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL add_ready got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd5 || out_b !== 32'd3)
      begin n_err++; $display("FAIL add_ops got v=%b a=%h b=%h want 1/5/3", out_valid, out_a, out_b); end
    n_cmp++; if (out_sel !== ALU_ADD || out_rd !== 5'd3)
      begin n_err++; $display("FAIL add_sel_rd got sel=%0d rd=%0d want ADD/3", out_sel, out_rd); end
    in_instr = rtype(5'd3, 5'd1, 5'd5, FN_SUB);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_ready_0 got %b want 0", in_ready); end
    step();
    n_cmp++; if (in_ready !== 1'b0 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL raw_ready_1 got rdy=%b v=%b want 0/0", in_ready, out_valid); end
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd100;
    #1;
`ifdef FORWARD_EN
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL raw_fwd_ready got %b want 1", in_ready); end
    step();
    wb_valid = 1'b0; in_valid = 1'b0;
`else
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL raw_wbcyc_ready got %b want 0", in_ready); end
    step();
    wb_valid = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL raw_after_wb got rdy=%b v=%b want 1/0", in_ready, out_valid); end
    step();
    in_valid = 1'b0;
`endif
    n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd100 || out_b !== 32'd5)
      begin n_err++; $display("FAIL sub_ops got v=%b a=%h b=%h want 1/64/5", out_valid, out_a, out_b); end
    n_cmp++; if (out_sel !== ALU_SUB || out_rd !== 5'd5)
      begin n_err++; $display("FAIL sub_sel_rd got sel=%0d rd=%0d want SUB/5", out_sel, out_rd); end
    step();
    wb(5'd5, 32'd42);
  endtask

  task automatic test_scoreboard_edges();
    in_instr = rtype(5'd1, 5'd1, 5'd8, FN_ADD); in_valid = 1'b1;
    wb_valid = 1'b1; wb_rd = 5'd8; wb_data = 32'd7;
    step();
    in_valid = 1'b0; wb_valid = 1'b0;
    in_instr = rtype(5'd8, 5'd0, 5'd0, FN_OR);
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL set_wins got rdy=%b want 0", in_ready); end
    wb(5'd8, 32'd9);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL wb_clears got rdy=%b want 1", in_ready); end
    in_valid = 1'b1;
    step();
    n_cmp++; if (out_a !== 32'd9) begin n_err++; $display("FAIL r8_read got %h want 9", out_a); end
    in_valid = 1'b0;
    wb(5'd9, 32'd77);
    in_instr = rtype(5'd9, 5'd2, 5'd0, FN_ADD); in_valid = 1'b1;
    step();
    in_instr = rtype(5'd0, 5'd0, 5'd0, FN_ADD);
    #1;
    n_cmp++; if (out_a !== 32'd77 || out_b !== 32'd3 || out_rd !== 5'd0)
      begin n_err++; $display("FAIL nonpend_wb got a=%h b=%h rd=%0d want 4d/3/0", out_a, out_b, out_rd); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL r0_not_pending got %b want 1", in_ready); end
    in_valid = 1'b0;
    wb(5'd0, 32'hDEAD_BEEF);
    in_instr = rtype(5'd0, 5'd0, 5'd0, FN_ADD); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_a !== 32'd0) begin n_err++; $display("FAIL r0_write_ignored got %h want 0", out_a); end
    step();
  endtask

  task automatic test_immediates();
    in_valid = 1'b1;
    in_instr = itype(OPC_ADDI, 5'd0, 5'd4, 16'hFFFF);
    step();
    n_cmp++; if (out_a !== 32'd0 || out_b !== 32'hFFFF_FFFF || out_sel !== ALU_ADD || out_rd !== 5'd4)
      begin n_err++; $display("FAIL addi got a=%h b=%h sel=%0d rd=%0d want 0/ffffffff/ADD/4", out_a, out_b, out_sel, out_rd); end
    in_instr = itype(OPC_ANDI, 5'd0, 5'd4, 16'hFFFF);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL andi_ready got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_b !== 32'h0000_FFFF || out_sel !== ALU_AND)
      begin n_err++; $display("FAIL andi got b=%h sel=%0d want 0000ffff/AND", out_b, out_sel); end
    in_instr = itype(OPC_SLTI, 5'd1, 5'd6, 16'hFFFE);
    step();
    n_cmp++; if (out_a !== 32'd5 || out_b !== 32'hFFFF_FFFE || out_sel !== ALU_SLT || out_rd !== 5'd6)
      begin n_err++; $display("FAIL slti got a=%h b=%h sel=%0d rd=%0d want 5/fffffffe/SLT/6", out_a, out_b, out_sel, out_rd); end
    in_instr = itype(OPC_ORI, 5'd2, 5'd7, 16'h8000);
    step();
    n_cmp++; if (out_a !== 32'd3 || out_b !== 32'h0000_8000 || out_sel !== ALU_OR || out_rd !== 5'd7)
      begin n_err++; $display("FAIL ori got a=%h b=%h sel=%0d rd=%0d want 3/00008000/OR/7", out_a, out_b, out_sel, out_rd); end
    in_instr = rtype(5'd1, 5'd2, 5'd0, FN_NOR);
    step();
    n_cmp++; if (out_sel !== ALU_NOR || out_a !== 32'd5 || out_b !== 32'd3)
      begin n_err++; $display("FAIL nor got sel=%0d a=%h b=%h want NOR/5/3", out_sel, out_a, out_b); end
    in_instr = rtype(5'd2, 5'd1, 5'd0, FN_SLT);
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_sel !== ALU_SLT || out_a !== 32'd3 || out_b !== 32'd5)
      begin n_err++; $display("FAIL slt got sel=%0d a=%h b=%h want SLT/3/5", out_sel, out_a, out_b); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_instr = rtype(5'd1, 5'd2, 5'd10, FN_ADD);
    step();
    in_instr = rtype(5'd1, 5'd2, 5'd11, FN_OR);
    for (int k = 0; k < 3; k++) begin
      #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_a !== 32'd5 || out_b !== 32'd3 || out_sel !== ALU_ADD ||
          out_rd !== 5'd10 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL hold_cyc%0d got v=%b a=%h b=%h sel=%0d rd=%0d rdy=%b want 1/5/3/ADD/10/0",
                          k, out_valid, out_a, out_b, out_sel, out_rd, in_ready);
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_ready got %b want 1", in_ready); end
    step();
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== ALU_OR || out_rd !== 5'd11)
      begin n_err++; $display("FAIL b2b_1 got v=%b sel=%0d rd=%0d want 1/OR/11", out_valid, out_sel, out_rd); end
    in_instr = rtype(5'd1, 5'd2, 5'd12, FN_AND);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_sel !== ALU_AND || out_rd !== 5'd12)
      begin n_err++; $display("FAIL b2b_2 got v=%b sel=%0d rd=%0d want 1/AND/12", out_valid, out_sel, out_rd); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL drain got v=%b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    in_instr = itype(6'h3F, 5'd1, 5'd13, 16'h6800); in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL ill_pulse got ill=%b v=%b want 1/0", illegal, out_valid); end
    step();
    n_cmp++; if (illegal !== 1'b0) begin n_err++; $display("FAIL ill_one_cycle got %b want 0", illegal); end
    in_instr = rtype(5'd13, 5'd0, 5'd0, FN_OR);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_no_pending got %b want 1", in_ready); end
    in_instr = rtype(5'd10, 5'd11, 5'd13, 6'h21); in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_no_hazard got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (illegal !== 1'b1 || out_valid !== 1'b0)
      begin n_err++; $display("FAIL ill_funct got ill=%b v=%b want 1/0", illegal, out_valid); end
    in_instr = rtype(5'd13, 5'd0, 5'd0, FN_OR);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL ill_funct_sb got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_instr = rtype(5'd1, 5'd2, 5'd15, FN_ADD); in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre got v=%b want 1", out_valid); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_a !== 32'd0)
      begin n_err++; $display("FAIL mid_rst got v=%b a=%h want 0/0", out_valid, out_a); end
    step();
    rst_n = 1'b1; out_ready = 1'b1;
    in_instr = rtype(5'd10, 5'd1, 5'd0, FN_OR); in_valid = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mid_sb_clear got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || out_a !== 32'd0 || out_b !== 32'd0)
      begin n_err++; $display("FAIL mid_rf_clear got v=%b a=%h b=%h want 1/0/0", out_valid, out_a, out_b); end
    step();
  endtask

  initial begin
    test_reset();
    test_issue_and_hazard();
    test_scoreboard_edges();
    test_immediates();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
